// File: rtl/rom_fetch_sequencer_if.sv
// Fetch-side bundle between the sequencer, the asynchronous program ROM and decode.
// The master (sequencer) drives the ROM address, the instruction stage and the status signals.
interface rom_fetch_sequencer_if #(
    parameter int ROM_WIDTH  = 21,
    parameter int ADDR_WIDTH = 16
);
    logic                  START;
    logic [ADDR_WIDTH-1:0] ROM_ADDR;
    logic [ROM_WIDTH-1:0]  ROM_DATA;
    logic [ROM_WIDTH-1:0]  INSTR;
    logic [ADDR_WIDTH-1:0] INSTR_PC;
    logic                  INSTR_VALID;
    logic                  INSTR_READY;
    logic                  JMP_VALID;
    logic [ADDR_WIDTH-1:0] JMP_ADDR;
    logic                  HALT_REQ;
    logic                  DONE;
    logic [1:0]            STATE;

    // Handshake: decode takes INSTR/INSTR_PC on any rising edge where INSTR_VALID
    // and INSTR_READY are both high; INSTR_VALID never drops while unaccepted,
    // except when a jump flushes the stage or reset clears it.
    modport master (
        input  START, ROM_DATA, INSTR_READY, JMP_VALID, JMP_ADDR, HALT_REQ,
        output ROM_ADDR, INSTR, INSTR_PC, INSTR_VALID, DONE, STATE
    );

    modport slave (
        output START, ROM_DATA, INSTR_READY, JMP_VALID, JMP_ADDR, HALT_REQ,
        input  ROM_ADDR, INSTR, INSTR_PC, INSTR_VALID, DONE, STATE
    );
endinterface

// File: rtl/rom_fetch_sequencer.sv
// Program counter and fetch controller: addresses the asynchronous ROM and registers
// each returned word into a one-entry output stage toward decode.
module rom_fetch_sequencer #(
    parameter int ROM_WIDTH  = 21,
    parameter int ADDR_WIDTH = 16,
    parameter int RESET_PC   = 0,
    parameter int PROG_LAST  = 9
) (
    input logic                   CLK,
    input logic                   nRST,
    rom_fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ROM_WIDTH-1:0]  instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  fetch_en;
    logic                  accept;

    assign fetch_en = (state_q == ST_FETCH) && !bus.HALT_REQ && !bus.JMP_VALID &&
                      (!instr_valid_q || bus.INSTR_READY);
    assign accept   = instr_valid_q && bus.INSTR_READY;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        if (state_q == ST_IDLE) begin
            if (bus.START) begin
                state_d = ST_FETCH;
            end
        end else if (bus.JMP_VALID) begin
            // A redirect discards the staged word even if decode is ready for it.
            pc_d          = bus.JMP_ADDR;
            instr_valid_d = 1'b0;
            state_d       = bus.HALT_REQ ? ST_HALT : ST_FETCH;
        end else begin
            if (accept) begin
                instr_valid_d = 1'b0;
            end
            if (fetch_en) begin
                instr_d       = bus.ROM_DATA;
                instr_pc_d    = pc_q;
                instr_valid_d = 1'b1;
                pc_d          = pc_q + ADDR_WIDTH'(1);
            end
            case (state_q)
                ST_FETCH: begin
                    if (bus.HALT_REQ) begin
                        state_d = ST_HALT;
                    end else if (fetch_en && (pc_q == ADDR_WIDTH'(PROG_LAST))) begin
                        state_d = ST_DONE;
                    end
                end
                ST_HALT: begin
                    if (!bus.HALT_REQ) begin
                        state_d = ST_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q       <= ST_IDLE;
            pc_q          <= ADDR_WIDTH'(RESET_PC);
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign bus.ROM_ADDR    = pc_q;
    assign bus.INSTR       = instr_q;
    assign bus.INSTR_PC    = instr_pc_q;
    assign bus.INSTR_VALID = instr_valid_q;
    assign bus.STATE       = state_q;
    assign bus.DONE        = (state_q == ST_DONE) && !instr_valid_q;
endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Directed bench for rom_fetch_sequencer: vector table for straight-line fetch and
// backpressure, hand sequences for jump, halt, done-exit, reset and address wrap.
module tb_rom_fetch_sequencer;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef struct {
        bit          rst_n;
        bit          start;
        bit          ready;
        bit          jmp;
        logic [15:0] jaddr;
        bit          halt;
        bit          e_valid;
        logic [15:0] e_ipc;
        logic [15:0] e_raddr;
        logic [1:0]  e_state;
        bit          e_done;
    } vec_t;

    logic CLK;
    logic nRST;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] exp_q[$];
    vec_t tbl[24];

    rom_fetch_sequencer_if bus ();

    rom_fetch_sequencer dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Program ROM model: ten words, then a recognisable filler pattern.
    function automatic logic [20:0] rom_word(input logic [15:0] a);
        if (a == 16'd0) return 21'h1D0001;
        if (a <= 16'd9) return {5'(a), a};
        return 21'h1F0000 | {5'd0, a};
    endfunction

    always_comb bus.ROM_DATA = rom_word(bus.ROM_ADDR);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rst_n, bit start, bit ready, bit jmp, logic [15:0] jaddr,
                                bit halt, bit ev, logic [15:0] eipc, logic [15:0] era,
                                logic [1:0] est, bit edone);
        vec_t v;
        v.rst_n = rst_n; v.start = start; v.ready = ready; v.jmp = jmp;
        v.jaddr = jaddr; v.halt = halt;
        v.e_valid = ev; v.e_ipc = eipc; v.e_raddr = era; v.e_state = est; v.e_done = edone;
        return v;
    endfunction

    // Driver: apply one cycle of inputs, then check outputs #1 after the edge.
    task automatic step(input vec_t v, input string name);
        nRST            = v.rst_n;
        bus.START       = v.start;
        bus.INSTR_READY = v.ready;
        bus.JMP_VALID   = v.jmp;
        bus.JMP_ADDR    = v.jaddr;
        bus.HALT_REQ    = v.halt;
        @(posedge CLK);
        #1;
        check({name, ".valid"}, 32'(bus.INSTR_VALID), 32'(v.e_valid));
        check({name, ".instr_pc"}, 32'(bus.INSTR_PC), 32'(v.e_ipc));
        check({name, ".rom_addr"}, 32'(bus.ROM_ADDR), 32'(v.e_raddr));
        check({name, ".state"}, 32'(bus.STATE), 32'(v.e_state));
        check({name, ".done"}, 32'(bus.DONE), 32'(v.e_done));
        if (v.e_valid)
            check({name, ".instr"}, 32'(bus.INSTR), 32'(rom_word(v.e_ipc)));
        else if (!v.rst_n)
            check({name, ".instr_rst"}, 32'(bus.INSTR), 32'd0);
    endtask

    // Scoreboard: every handshake decode completes must match the next expected PC.
    always @(negedge CLK) begin
        if (nRST === 1'b1 && bus.INSTR_VALID === 1'b1 && bus.INSTR_READY === 1'b1 &&
            bus.JMP_VALID === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb.unexpected: got pc %0h, required no transfer", bus.INSTR_PC);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("sb.pc", 32'(bus.INSTR_PC), 32'(e));
                check("sb.instr", 32'(bus.INSTR), 32'(rom_word(e)));
            end
        end
    end

    initial begin
        // Straight-line program run, then backpressure at INSTR_PC=2.
        tbl[0]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, S_IDLE, 0);
        tbl[1]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, S_FETCH, 0);
        for (int k = 0; k < 10; k++)
            tbl[2 + k] = mk(1, 0, 1, 0, 0, 0, 1, 16'(k), 16'(k + 1),
                            (k == 9) ? S_DONE : S_FETCH, 0);
        tbl[12] = mk(1, 0, 1, 0, 0, 0, 0, 9, 10, S_DONE, 1);
        tbl[13] = mk(1, 0, 1, 0, 0, 0, 0, 9, 10, S_DONE, 1);
        tbl[14] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, S_IDLE, 0);
        tbl[15] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, S_FETCH, 0);
        tbl[16] = mk(1, 0, 1, 0, 0, 0, 1, 0, 1, S_FETCH, 0);
        tbl[17] = mk(1, 0, 1, 0, 0, 0, 1, 1, 2, S_FETCH, 0);
        tbl[18] = mk(1, 0, 1, 0, 0, 0, 1, 2, 3, S_FETCH, 0);
        tbl[19] = mk(1, 0, 0, 0, 0, 0, 1, 2, 3, S_FETCH, 0);
        tbl[20] = mk(1, 0, 0, 0, 0, 0, 1, 2, 3, S_FETCH, 0);
        tbl[21] = mk(1, 0, 0, 0, 0, 0, 1, 2, 3, S_FETCH, 0);
        tbl[22] = mk(1, 0, 1, 0, 0, 0, 1, 3, 4, S_FETCH, 0);
        tbl[23] = mk(1, 0, 1, 0, 0, 0, 1, 4, 5, S_FETCH, 0);

        for (int k = 0; k < 10; k++) exp_q.push_back(16'(k));
        for (int k = 0; k < 4; k++) exp_q.push_back(16'(k));

        for (int i = 0; i < 24; i++) step(tbl[i], $sformatf("vec%0d", i));

        // Jump back to 1 while INSTR_PC=5 is live.
        exp_q.push_back(16'd4);
        step(mk(1, 0, 1, 0, 0, 0, 1, 5, 6, S_FETCH, 0), "jmp_pre");
        step(mk(1, 0, 1, 1, 1, 0, 0, 5, 1, S_FETCH, 0), "jmp_flush");
        step(mk(1, 0, 1, 0, 0, 0, 1, 1, 2, S_FETCH, 0), "jmp_refetch");

        // Halt for 4 clocks with ROM_ADDR=4, then release.
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd2);
        exp_q.push_back(16'd3);
        step(mk(1, 0, 1, 0, 0, 0, 1, 2, 3, S_FETCH, 0), "pre_halt0");
        step(mk(1, 0, 1, 0, 0, 0, 1, 3, 4, S_FETCH, 0), "pre_halt1");
        for (int k = 0; k < 4; k++)
            step(mk(1, 0, 1, 0, 0, 1, 0, 3, 4, S_HALT, 0), $sformatf("halt%0d", k));
        step(mk(1, 0, 1, 0, 0, 0, 0, 3, 4, S_FETCH, 0), "halt_release");
        step(mk(1, 0, 1, 0, 0, 0, 1, 4, 5, S_FETCH, 0), "halt_resume");

        // Jump and halt together, then run to DONE; HALT_REQ ignored in DONE.
        exp_q.push_back(16'd7);
        exp_q.push_back(16'd8);
        exp_q.push_back(16'd9);
        step(mk(1, 0, 1, 1, 7, 1, 0, 4, 7, S_HALT, 0), "jmp_halt");
        step(mk(1, 0, 1, 0, 0, 0, 0, 4, 7, S_FETCH, 0), "jh_release");
        step(mk(1, 0, 1, 0, 0, 0, 1, 7, 8, S_FETCH, 0), "jh_f7");
        step(mk(1, 0, 1, 0, 0, 0, 1, 8, 9, S_FETCH, 0), "jh_f8");
        step(mk(1, 0, 1, 0, 0, 0, 1, 9, 10, S_DONE, 0), "jh_f9");
        step(mk(1, 0, 0, 0, 0, 0, 1, 9, 10, S_DONE, 0), "done_hold");
        step(mk(1, 0, 1, 0, 0, 1, 0, 9, 10, S_DONE, 1), "done_drain");

        // Jump out of DONE replays from 0.
        for (int k = 0; k < 6; k++) exp_q.push_back(16'(k));
        step(mk(1, 0, 1, 1, 0, 0, 0, 9, 0, S_FETCH, 0), "done_jmp");
        for (int k = 0; k < 7; k++)
            step(mk(1, 0, 1, 0, 0, 0, 1, 16'(k), 16'(k + 1), S_FETCH, 0),
                 $sformatf("replay%0d", k));

        // Reset mid-stream beats a jump; IDLE ignores jump/halt until START.
        step(mk(0, 0, 1, 1, 3, 0, 0, 0, 0, S_IDLE, 0), "mid_reset");
        step(mk(1, 0, 1, 1, 5, 1, 0, 0, 0, S_IDLE, 0), "idle_ignore");
        step(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, S_FETCH, 0), "restart");
        step(mk(1, 0, 1, 0, 0, 0, 1, 0, 1, S_FETCH, 0), "restart_f0");

        // Jump past the program end: fetch continues and PC wraps, no DONE.
        step(mk(1, 0, 1, 1, 16'hFFFF, 0, 0, 0, 16'hFFFF, S_FETCH, 0), "far_jmp");
        step(mk(1, 0, 1, 0, 0, 0, 1, 16'hFFFF, 0, S_FETCH, 0), "wrap_fetch");
        step(mk(1, 0, 0, 0, 0, 0, 1, 16'hFFFF, 0, S_FETCH, 0), "wrap_hold");

        @(negedge CLK);
        check("sb.drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
